// File: rtl/dp_result_buffer.sv
// rtl/dp_result_buffer.sv - show-ahead result FIFO behind the datapath ALU
//
// Purpose:
//   Captures every ALU result qualified by valid_in and buffers it in a
//   DEPTH-entry show-ahead FIFO. A consumer drains the head through a
//   valid/ready handshake. The ALU cannot be stalled, so results that arrive
//   while the buffer is full and not draining are dropped. A dropped result
//   sets a sticky overflow flag. A wrapping counter tracks accepted results.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   valid_in    - ALU result valid
//   alu/carry/zero - ALU result and flags, stored unmodified
//   flush       - synchronous clear of contents, overflow and accept_cnt
//   out_valid   - head entry available
//   out_ready   - consumer accepts head entry (ignored when empty)
//   out_alu/out_carry/out_zero - head entry, forced to 0 when empty
//   count       - occupancy, 0..DEPTH
//   full/empty  - count == DEPTH / count == 0
//   overflow    - sticky: a result was dropped
//   accept_cnt  - number of results written, modulo 2^CNT_W

module dp_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [3:0]               alu,
  input  logic                     carry,
  input  logic                     zero,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_alu,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         accept_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry layout: {carry, zero, alu[3:0]}
  logic [5:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_accept_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [5:0]       w_head;

  // Status comes only from the registered occupancy, so no input reaches
  // an output combinationally.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same cycle, so a full buffer that is being
  // drained can still accept the incoming result.
  assign w_pop  = !w_empty && out_ready && !flush;
  assign w_push = valid_in && !flush && (!w_full || w_pop);
  assign w_drop = valid_in && !flush && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_accept_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_accept_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + PW'(1);
        r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {carry, zero, alu};
    end
  end

  assign w_head = w_empty ? 6'd0 : r_mem[r_rd_ptr];

  assign out_valid  = !w_empty;
  assign out_carry  = w_head[5];
  assign out_zero   = w_head[4];
  assign out_alu    = w_head[3:0];
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;
  assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_dp_result_buffer.sv
// tb/tb_dp_result_buffer.sv - scoreboard bench for dp_result_buffer
module tb_dp_result_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  logic [3:0]       alu = '0;
  logic             carry = 1'b0;
  logic             zero = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_alu;
  logic             out_carry;
  logic             out_zero;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] accept_cnt;

  dp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu(alu), .carry(carry),
    .zero(zero), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_carry(out_carry), .out_zero(out_zero),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: expected contents, sticky overflow, accept counter.
  logic [5:0]       q[$];
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_acc = '0;
  logic             m_pop;
  logic             m_push;
  logic [5:0]       cap;
  logic [5:0]       exp_head;

  // Drive one cycle. Inputs change 1 time unit after the rising edge, so the
  // head captured here is the value the DUT presents at the coming edge.
  task automatic cycle(input logic v, input logic [3:0] a, input logic c,
                       input logic z, input logic rdy, input logic fl);
    valid_in = v; alu = a; carry = c; zero = z; out_ready = rdy; flush = fl;
    cap    = {out_carry, out_zero, out_alu};
    m_pop  = (q.size() > 0) && rdy && !fl;
    m_push = v && !fl && ((q.size() < DEPTH) || m_pop);
    if (m_pop) exp_head = q.pop_front();
    if (m_push) begin
      q.push_back({c, z, a});
      m_acc = m_acc + 8'd1;
    end
    if (v && !fl && !m_push) m_ovf = 1'b1;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_acc = '0;
    end
    @(posedge clk); #1;
    valid_in = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_carry, out_zero, out_alu} !== 6'h00) begin errors++; $display("FAIL reset_head got=%h exp=00", {out_carry, out_zero, out_alu}); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_full_empty got=%b%b exp=01", full, empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (accept_cnt !== 8'd0) begin errors++; $display("FAIL reset_accept got=%0d exp=0", accept_cnt); end
  endtask

  task automatic test_fill();
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || {out_carry, out_zero, out_alu} !== 6'h03) begin errors++; $display("FAIL fill_first_latency got=%b/%h exp=1/03", out_valid, {out_carry, out_zero, out_alu}); end
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL fill_count got=%0d exp=3", count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid got=%b exp=1", out_valid); end
    checks++; if ({out_carry, out_zero, out_alu} !== 6'h03) begin errors++; $display("FAIL fill_head got=%h exp=03", {out_carry, out_zero, out_alu}); end
    checks++; if (accept_cnt !== 8'd3) begin errors++; $display("FAIL fill_accept got=%0d exp=3", accept_cnt); end
  endtask

  task automatic test_drain();
    logic [5:0] order [3];
    order[0] = 6'h03; order[1] = 6'h2F; order[2] = 6'h30;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL drain_scoreboard[%0d] got=%h exp=%h", i, cap, exp_head); end
      checks++; if (cap !== order[i]) begin errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, cap, order[i]); end
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty, out_valid); end
    checks++; if ({out_carry, out_zero, out_alu} !== 6'h00) begin errors++; $display("FAIL drain_mask got=%h exp=00", {out_carry, out_zero, out_alu}); end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 4'(i), i[0], 1'b0, 1'b0, 1'b0);
      if (i == 8) begin
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL ovf_full_at_8 got=%b/%0d exp=1/8", full, count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (accept_cnt !== 8'd8) begin errors++; $display("FAIL ovf_accept got=%0d exp=8", accept_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL flush_pre_drain[%0d] got=%h exp=%h", i, cap, exp_head); end
    end
    checks++; if (count !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL flush_setup got=%0d/%b exp=5/1", count, overflow); end
    cycle(1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/1/0", count, empty, out_valid); end
    checks++; if (overflow !== 1'b0 || accept_cnt !== 8'd0) begin errors++; $display("FAIL flush_flags got=%b/%0d exp=0/0", overflow, accept_cnt); end
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd1 || {out_carry, out_zero, out_alu} !== 6'h05) begin errors++; $display("FAIL flush_not_stored got=%0d/%h exp=1/05", count, {out_carry, out_zero, out_alu}); end
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL flush_post_drain got=%h exp=%h", cap, exp_head); end
  endtask

  task automatic test_full_push_pop();
    logic [5:0] last;
    last = '0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 4'(i), 1'b1, i[1], 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full got=%b exp=1", full); end
    cycle(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL fpp_pop got=%h exp=%h", cap, exp_head); end
    checks++; if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL fpp_state got=%0d/%b/%b exp=8/0/1", count, overflow, full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", i, cap, exp_head); end
      last = cap;
    end
    checks++; if (last !== 6'h1A) begin errors++; $display("FAIL fpp_last got=%h exp=1a", last); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_throughput_reset();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      if (i > 0) begin
        checks++; if (!m_pop || cap !== exp_head) begin errors++; $display("FAIL tput_pop[%0d] got=%h exp=%h", i, cap, exp_head); end
      end
    end
    checks++; if (accept_cnt !== 8'd44) begin errors++; $display("FAIL tput_accept got=%0d exp=44", accept_cnt); end
    checks++; if (accept_cnt !== m_acc) begin errors++; $display("FAIL tput_accept_model got=%0d exp=%0d", accept_cnt, m_acc); end
    checks++; if (overflow !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL tput_state got=%b/%0d exp=0/1", overflow, count); end
    valid_in = 1'b1; alu = 4'h7; out_ready = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL rst_async_status got=%b/%b/%0d exp=0/1/0", out_valid, empty, count); end
    checks++; if ({out_carry, out_zero, out_alu} !== 6'h00 || overflow !== 1'b0 || accept_cnt !== 8'd0 || full !== 1'b0) begin errors++; $display("FAIL rst_async_outputs got=%h/%b/%0d/%b exp=00/0/0/0", {out_carry, out_zero, out_alu}, overflow, accept_cnt, full); end
    valid_in = 1'b0; out_ready = 1'b0;
    q.delete(); m_ovf = 1'b0; m_acc = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd1 || {out_carry, out_zero, out_alu} !== 6'h1C || accept_cnt !== 8'd1) begin errors++; $display("FAIL rst_recover got=%0d/%h/%0d exp=1/1c/1", count, {out_carry, out_zero, out_alu}, accept_cnt); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_flush();
    test_full_push_pop();
    test_throughput_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
